// File: rtl/servo_pwm_dsm_array.sv
// rtl/servo_pwm_dsm_array.sv - per-channel PWM and delta-sigma servo outputs behind an Avalon-MM register slave
// Delta-sigma accumulators exist only when SERVO_PWM_DSM_DSM_EN is defined; otherwise servo_dsm is tied low.
module servo_pwm_dsm_array #(
  parameter int CHANNELS         = 8,
  parameter int WIDTH            = 16,
  parameter int DEFAULT_PRESCALE = 99,
  parameter int DEFAULT_PERIOD   = 19999
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4:0]          avs_address,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [CHANNELS-1:0] servo_pwm,
  output logic [CHANNELS-1:0] servo_dsm,
  output logic                frame_irq
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [7:0]       CH_COUNT = 8'(CHANNELS);

  logic                r_en;
  logic                r_irqen;
  logic                r_frame;
  logic [WIDTH-1:0]    r_period;
  logic [WIDTH-1:0]    r_prescale;
  logic [WIDTH-1:0]    r_pcnt;
  logic [WIDTH-1:0]    r_fcnt;
  logic [WIDTH-1:0]    r_pulse  [CHANNELS];
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;
  logic [31:0]         r_rdata;

  logic                w_wr_ctrl;
  logic                w_wr_period;
  logic                w_wr_prescale;
  logic                w_w1c_frame;
  logic                w_en_nxt;
  logic                w_dsmen;
  logic                w_run;
  logic                w_tick;
  logic                w_wrap;
  logic                w_unused_wdata;
  logic [WIDTH-1:0]    w_pcnt_nxt;
  logic [WIDTH-1:0]    w_fcnt_nxt;
  logic [WIDTH-1:0]    w_pulse_nxt  [CHANNELS];
  logic [WIDTH-1:0]    w_shadow_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_pwm_nxt;
  logic [31:0]         w_rdata_nxt;

  assign w_wr_ctrl      = avs_write && (avs_address == 5'd0);
  assign w_wr_period    = avs_write && (avs_address == 5'd1);
  assign w_wr_prescale  = avs_write && (avs_address == 5'd2);
  assign w_w1c_frame    = avs_write && (avs_address == 5'd3) && avs_writedata[0];
  assign w_en_nxt       = w_wr_ctrl ? avs_writedata[0] : r_en;
  assign w_unused_wdata = ^avs_writedata;

  // Counters only run while EN is set now and stays set; a clearing write parks them at 0 at once.
  assign w_run      = r_en && w_en_nxt;
  assign w_tick     = w_run && (r_pcnt == r_prescale);
  assign w_wrap     = w_tick && ((r_fcnt == r_period) || (r_fcnt == ALL_ONES));
  assign w_pcnt_nxt = (!w_run || w_tick) ? '0 : r_pcnt + 1'b1;
  assign w_fcnt_nxt = (!w_run || w_wrap) ? '0 : (w_tick ? r_fcnt + 1'b1 : r_fcnt);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_pulse_nxt[i] = r_pulse[i];
      if (avs_write && (avs_address == 5'(16 + i)))
        w_pulse_nxt[i] = avs_writedata[WIDTH-1:0];
      // Wrap captures the pre-write pulse so a same-cycle write lands one frame later.
      w_shadow_nxt[i] = !r_en ? w_pulse_nxt[i] : (w_wrap ? r_pulse[i] : r_shadow[i]);
      w_pwm_nxt[i]    = w_en_nxt && (w_fcnt_nxt < w_shadow_nxt[i]);
    end
  end

  always_comb begin
    w_rdata_nxt = '0;
    case (avs_address)
      5'd0:    w_rdata_nxt = {29'd0, w_dsmen, r_irqen, r_en};
      5'd1:    w_rdata_nxt[WIDTH-1:0] = r_period;
      5'd2:    w_rdata_nxt[WIDTH-1:0] = r_prescale;
      5'd3:    w_rdata_nxt = {16'd0, CH_COUNT, 7'd0, r_frame};
      default: begin
        for (int i = 0; i < CHANNELS; i++)
          if (avs_address == 5'(16 + i))
            w_rdata_nxt[WIDTH-1:0] = r_pulse[i];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_en       <= 1'b0;
      r_irqen    <= 1'b0;
      r_frame    <= 1'b0;
      r_period   <= WIDTH'(DEFAULT_PERIOD);
      r_prescale <= WIDTH'(DEFAULT_PRESCALE);
      r_pcnt     <= '0;
      r_fcnt     <= '0;
      r_pwm      <= '0;
      r_rdata    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_pulse[i]  <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      r_en    <= w_en_nxt;
      r_irqen <= w_wr_ctrl ? avs_writedata[1] : r_irqen;
      if (w_wr_period)
        r_period <= avs_writedata[WIDTH-1:0];
      if (w_wr_prescale)
        r_prescale <= avs_writedata[WIDTH-1:0];
      // A wrap on the same edge as a W1C keeps FRAME set.
      r_frame <= w_wrap ? 1'b1 : (w_w1c_frame ? 1'b0 : r_frame);
      r_pcnt  <= w_pcnt_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_pwm   <= w_pwm_nxt;
      r_rdata <= avs_read ? w_rdata_nxt : '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_pulse[i]  <= w_pulse_nxt[i];
        r_shadow[i] <= w_shadow_nxt[i];
      end
    end
  end

`ifdef SERVO_PWM_DSM_DSM_EN
  logic                r_dsmen;
  logic [WIDTH:0]      r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_dsm;
  logic                w_dsmen_nxt;
  logic [WIDTH:0]      w_acc_nxt [CHANNELS];

  assign w_dsmen_nxt = w_wr_ctrl ? avs_writedata[2] : r_dsmen;
  assign w_dsmen     = r_dsmen;
  assign servo_dsm   = r_dsm;

  // First-order modulator on the live pulse value; the carry out is the output bit.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      w_acc_nxt[i] = w_dsmen_nxt ? ({1'b0, r_acc[i][WIDTH-1:0]} + {1'b0, r_pulse[i]}) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dsmen <= 1'b0;
      r_dsm   <= '0;
      for (int i = 0; i < CHANNELS; i++)
        r_acc[i] <= '0;
    end else begin
      r_dsmen <= w_dsmen_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= w_acc_nxt[i];
        r_dsm[i] <= w_acc_nxt[i][WIDTH];
      end
    end
  end
`else
  assign w_dsmen   = 1'b0;
  assign servo_dsm = '0;
`endif

  assign servo_pwm    = r_pwm;
  assign avs_readdata = r_rdata;
  assign frame_irq    = r_frame & r_irqen;

endmodule

// File: doc/servo_pwm_dsm_array.md
Name: servo_pwm_dsm_array

Overview:
- Parametrised servo/actuator output block with an Avalon-MM slave register interface. It succeeds the fixed 8-channel servo_pwm/servo_dsm conduit.
- CHANNELS independent outputs, each driven two ways from one pulse-width register:
  - a period-synchronous PWM output;
  - a first-order delta-sigma (DSM) output.
- Sits on the system bus in the 100 MHz domain; its pwm/dsm vectors are exported as top-level conduits.

Parameters:
- CHANNELS, 8, number of output channels, 1..16
- WIDTH, 16, bit width of period, prescale and pulse-width registers, 8..24
- DEFAULT_PRESCALE, 99, reset value of PRESCALE (1 us tick at 100 MHz)
- DEFAULT_PERIOD, 19999, reset value of PERIOD (20 ms frame with a 1 us tick)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- avs_address  in  5  register word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid 1 cycle after avs_read
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- servo_pwm  out  CHANNELS  PWM outputs
- servo_dsm  out  CHANNELS  delta-sigma outputs
- frame_irq  out  1  level interrupt = STATUS.FRAME & CTRL.IRQEN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on reset_n.
- Register map (word addresses):
  - 0 CTRL: bit0 EN, bit1 IRQEN, bit2 DSMEN.
  - 1 PERIOD [WIDTH-1:0].
  - 2 PRESCALE [WIDTH-1:0].
  - 3 STATUS: bit0 FRAME (W1C); bits [15:8] = CHANNELS, read-only.
  - 16+i: PULSE[i] [WIDTH-1:0], for i < CHANNELS.
  - Unmapped addresses read 0; writes to them are ignored. Unused upper bits read 0.
- Bus timing: no waitrequest. Writes take effect on the clock edge at which avs_write is sampled. Read latency is exactly 1 cycle.
- Reset values:
  - CTRL=0, STATUS.FRAME=0, PULSE[*]=0, shadow[*]=0;
  - PRESCALE=DEFAULT_PRESCALE, PERIOD=DEFAULT_PERIOD;
  - counters=0, DSM accumulators=0;
  - servo_pwm=0, servo_dsm=0, frame_irq=0, avs_readdata=0.
- Prescaler: pcnt counts 0..PRESCALE, one clk per step. tick=1 on the cycle pcnt==PRESCALE, and pcnt returns to 0 on that cycle. PRESCALE=0 gives tick every cycle.
- Frame counter:
  - fcnt advances on each tick, counting 0..PERIOD.
  - On a tick with fcnt==PERIOD ("wrap"): fcnt<=0, shadow[i]<=PULSE[i] for all i, FRAME<=1.
  - PERIOD=0: every tick is a wrap.
- CTRL.EN=0:
  - pcnt and fcnt are held at 0; servo_pwm=0.
  - shadow[i] continuously tracks PULSE[i], so enabling starts a frame with current values.
- EN 0->1: the first frame starts at fcnt=0, pcnt=0 on the next cycle.
- PWM output:
  - servo_pwm[i] is registered: servo_pwm[i] <= EN & (fcnt_next < shadow_next[i]), giving 1-cycle latency from the counter.
  - shadow[i]=0 → constant low.
  - shadow[i] > PERIOD → constant high.
- Glitch-free update: a PULSE write mid-frame never alters the current frame.
- Simultaneous events:
  - PULSE write on the wrap cycle: shadow loads the pre-write value; the new value applies from the next frame.
  - STATUS W1C on the same cycle as a wrap: the set wins, so FRAME stays 1.
- PERIOD or PRESCALE write mid-frame: takes effect immediately.
  - If the new PERIOD < fcnt, the counter continues to the WIDTH-bit all-ones value, then wraps to 0 and counts as a wrap.
  - Software must write PERIOD only while EN=0.

Optional Feature:
- Macro: SERVO_PWM_DSM_DSM_EN.
- Defined:
  - Per channel, a (WIDTH+1)-bit accumulator runs every clk while DSMEN=1: acc <= {1'b0, acc[WIDTH-1:0]} + PULSE[i].
  - servo_dsm[i] <= carry bit acc_next[WIDTH].
  - DSM uses live PULSE, not shadow.
  - Output density = PULSE / 2^WIDTH.
  - DSMEN=0: accumulators are cleared to 0 and servo_dsm=0.
- Undefined:
  - No accumulators are built; servo_dsm is tied to 0.
  - CTRL.DSMEN reads 0 and writes to it are ignored.

Test Plan:
- Reset and readback: after reset, read CTRL=0, PERIOD=19999, PRESCALE=99, STATUS=0x0800 (CHANNELS=8); servo_pwm=0.
- PWM duty: PRESCALE=0, PERIOD=9, PULSE[0]=3, PULSE[1]=0, PULSE[2]=15, EN=1 → after the first wrap, ch0 high 3 of every 10 clks, ch1 always low, ch2 always high.
- Shadow and write on wrap: mid-frame write PULSE[0]=7 → current frame keeps 3, next frame shows 7. Repeat the write on the exact wrap cycle → old value holds for one more frame.
- Interrupt race: IRQEN=1 → frame_irq rises 1 cycle after the wrap. W1C STATUS on a non-wrap cycle → FRAME=0 and irq low. W1C on the wrap cycle → FRAME stays 1.
- Prescale timing: PRESCALE=3, PERIOD=4 → wrap every 20 clks; FRAME set interval measured as 20.
- DSM density (macro defined): WIDTH=16, PULSE[3]=0x4000, DSMEN=1 → exactly 256 ones in 1024 clks, never two consecutive ones. DSMEN=0 → servo_dsm[3]=0 the next cycle.
